// File: rtl/accel_mem_bridge_pipelined.sv
// Accelerator command word to Avalon-MM master bridge: one holding register, in-order read FIFO, sticky errors.
// Optional: define ATM_BRIDGE_SIGN_EXT_EN to sign-extend reads whose command has the signed bit set.
module accel_mem_bridge_pipelined #(
   parameter int ADDR_W          = 31,
   parameter int MEM_DATA_W      = 64,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [MEM_DATA_W+35:0]  cmd_from_accel,
   input  logic                    read_from_accel,
   input  logic                    write_from_accel,
   output logic                    waitrequest_to_accel,
   output logic [MEM_DATA_W-1:0]   readdata_to_accel,
   output logic                    readdatavalid_to_accel,
   output logic [ADDR_W-1:0]       address_to_mem,
   output logic                    read_to_mem,
   output logic                    write_to_mem,
   output logic [MEM_DATA_W-1:0]   writedata_to_mem,
   output logic [MEM_DATA_W/8-1:0] byteenable_to_mem,
   input  logic                    waitrequest_from_mem,
   input  logic [MEM_DATA_W-1:0]   readdata_from_mem,
   input  logic                    readdatavalid_from_mem,
   output logic [2:0]              err_status
);

   localparam int BYTES = MEM_DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int S     = 32 + MEM_DATA_W;
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {IDLE, HOLD} state_t;

   // Size code: 0=1 byte, 1=2 bytes, 2=4 bytes, 3=8 bytes; widest wins when several bits set.
   function automatic logic [1:0] size_code(input logic [2:0] m);
      if (m[2])      return 2'd3;
      else if (m[1]) return 2'd1;
      else if (m[0]) return 2'd0;
      else           return 2'd2;
   endfunction

   function automatic int unsigned size_bytes(input logic [1:0] code);
      return 32'd1 << code;
   endfunction

   function automatic logic [BYTES-1:0] be_mask(input logic [OFF_W-1:0] off, input logic [1:0] code);
      logic [BYTES-1:0] m;
      int lo, hi;
      lo = int'(off);
      hi = lo + int'(size_bytes(code));
      for (int b = 0; b < BYTES; b++) m[b] = (b >= lo) && (b < hi);
      return m;
   endfunction

   function automatic logic span_err(input logic [OFF_W-1:0] off, input logic [1:0] code);
      return (int'(off) + int'(size_bytes(code))) > BYTES;
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [MEM_DATA_W-1:0] fmt_rdata(input logic [MEM_DATA_W-1:0] d,
                                                       input logic [OFF_W-1:0] off,
                                                       input logic [1:0] code,
                                                       input logic sgn);
      logic [MEM_DATA_W-1:0] sh, r;
      logic                  sbit;
      int                    nb;
      sh = d >> {off, 3'b000};
      nb = int'(size_bytes(code));
      if (nb > BYTES) nb = BYTES;
      sbit = sh[nb*8-1];
      r = '0;
      for (int b = 0; b < BYTES; b++) begin
         if (b < nb) r[b*8 +: 8] = sh[b*8 +: 8];
         else        r[b*8 +: 8] = {8{sgn & sbit}};
      end
      return r;
   endfunction

   logic [31:0]           cmd_addr;
   logic [MEM_DATA_W-1:0] cmd_wdata;
   logic [1:0]            cmd_size;
   logic [OFF_W-1:0]      cmd_off;
   logic                  cmd_sgn;
   logic                  unused_cmd_bits;

   assign cmd_addr        = cmd_from_accel[31:0];
   assign cmd_wdata       = cmd_from_accel[32 +: MEM_DATA_W];
   assign cmd_size        = size_code(cmd_from_accel[S +: 3]);
   assign cmd_sgn         = cmd_from_accel[S+3];
   assign cmd_off         = cmd_addr[OFF_W-1:0];
   assign unused_cmd_bits = ^cmd_addr ^ cmd_sgn;

   state_t                state_q, state_d;
   logic                  rd_q, wr_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [MEM_DATA_W-1:0] wdata_q;
   logic [BYTES-1:0]      be_q;
   logic [OFF_W-1:0]      off_q;
   logic [1:0]            sz_q;
`ifdef ATM_BRIDGE_SIGN_EXT_EN
   logic                  sgn_q;
   logic                  fifo_sgn_q [MAX_OUTSTANDING];
`endif
   logic [OFF_W-1:0]      fifo_off_q [MAX_OUTSTANDING];
   logic [1:0]            fifo_sz_q  [MAX_OUTSTANDING];
   logic [PTR_W-1:0]      wptr_q, rptr_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2:0]            err_q;
   logic                  rvalid_q;
   logic [MEM_DATA_W-1:0] rdata_q;

   logic req_valid, held_rd, issue, accept, rd_full, push, pop, head_sgn;

   assign req_valid = (state_q == HOLD);
   assign held_rd   = req_valid & rd_q;
   assign issue     = req_valid & ~waitrequest_from_mem;
   // The held read is counted even while it issues: the counter only reflects it a cycle later.
   assign rd_full   = ({1'b0, cnt_q} + (CNT_W+1)'(held_rd)) >= (CNT_W+1)'(MAX_OUTSTANDING);
   assign waitrequest_to_accel = (req_valid & waitrequest_from_mem) | (read_from_accel & rd_full);
   assign accept    = (read_from_accel | write_from_accel) & ~waitrequest_to_accel;
   assign push      = issue & rd_q;
   assign pop       = readdatavalid_from_mem & (cnt_q != '0);

`ifdef ATM_BRIDGE_SIGN_EXT_EN
   assign head_sgn = fifo_sgn_q[rptr_q];
`else
   assign head_sgn = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = HOLD;
         HOLD:    if (issue && !accept) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         off_q    <= '0;
         sz_q     <= '0;
`ifdef ATM_BRIDGE_SIGN_EXT_EN
         sgn_q    <= 1'b0;
`endif
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         err_q    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            rd_q    <= read_from_accel & ~write_from_accel;
            wr_q    <= write_from_accel;
            addr_q  <= cmd_addr[ADDR_W-1:0];
            wdata_q <= cmd_wdata << {cmd_off, 3'b000};
            be_q    <= be_mask(cmd_off, cmd_size);
            off_q   <= cmd_off;
            sz_q    <= cmd_size;
`ifdef ATM_BRIDGE_SIGN_EXT_EN
            sgn_q   <= cmd_sgn;
`endif
         end
         if (push) wptr_q <= next_ptr(wptr_q);
         if (pop)  rptr_q <= next_ptr(rptr_q);
         err_q <= err_q | {accept & read_from_accel & write_from_accel,
                           readdatavalid_from_mem & (cnt_q == '0),
                           accept & span_err(cmd_off, cmd_size)};
         rvalid_q <= pop;
         if (pop) rdata_q <= fmt_rdata(readdata_from_mem, fifo_off_q[rptr_q], fifo_sz_q[rptr_q], head_sgn);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_off_q[wptr_q] <= off_q;
         fifo_sz_q[wptr_q]  <= sz_q;
`ifdef ATM_BRIDGE_SIGN_EXT_EN
         fifo_sgn_q[wptr_q] <= sgn_q;
`endif
      end
   end

   assign address_to_mem         = addr_q;
   assign read_to_mem            = req_valid & rd_q;
   assign write_to_mem           = req_valid & wr_q;
   assign writedata_to_mem       = wdata_q;
   assign byteenable_to_mem      = be_q;
   assign readdata_to_accel      = rdata_q;
   assign readdatavalid_to_accel = rvalid_q;
   assign err_status             = err_q;

endmodule

// File: tb/tb_accel_mem_bridge_pipelined.sv
// Scoreboard bench for accel_mem_bridge_pipelined; follows ATM_BRIDGE_SIGN_EXT_EN when defined.
module tb_accel_mem_bridge_pipelined;

   localparam int ADDR_W = 31;
   localparam int DW     = 64;
   localparam int MAXO   = 4;
   localparam int CMD_W  = DW + 36;

   logic             clk = 1'b0;
   logic             reset;
   logic [CMD_W-1:0] cmd;
   logic             rd, wr;
   logic             waitrequest_to_accel;
   logic [DW-1:0]    readdata_to_accel;
   logic             readdatavalid_to_accel;
   logic [ADDR_W-1:0] address_to_mem;
   logic             read_to_mem, write_to_mem;
   logic [DW-1:0]    writedata_to_mem;
   logic [7:0]       byteenable_to_mem;
   logic             wq_mem;
   logic [DW-1:0]    rdata_mem;
   logic             rvalid_mem;
   logic [2:0]       err_status;

   accel_mem_bridge_pipelined #(.ADDR_W(ADDR_W), .MEM_DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .reset(reset), .cmd_from_accel(cmd),
      .read_from_accel(rd), .write_from_accel(wr),
      .waitrequest_to_accel(waitrequest_to_accel),
      .readdata_to_accel(readdata_to_accel), .readdatavalid_to_accel(readdatavalid_to_accel),
      .address_to_mem(address_to_mem), .read_to_mem(read_to_mem), .write_to_mem(write_to_mem),
      .writedata_to_mem(writedata_to_mem), .byteenable_to_mem(byteenable_to_mem),
      .waitrequest_from_mem(wq_mem), .readdata_from_mem(rdata_mem),
      .readdatavalid_from_mem(rvalid_mem), .err_status(err_status));

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          wr_pulses = 0;
   logic [63:0] sb[$];
   logic [31:0] pend[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Memory image: byte at address a holds (a + 0x7B).
   function automatic logic [63:0] mem_word(input logic [31:0] a);
      logic [63:0] w;
      for (int i = 0; i < 8; i++) w[i*8 +: 8] = 8'((a & ~32'h7) + 32'(i) + 32'h7B);
      return w;
   endfunction

   function automatic logic [63:0] exp_read(input logic [31:0] a, input logic [2:0] sz, input logic sg);
      logic [63:0] w, r;
      int off, nb;
      off = int'(a[2:0]);
      nb  = sz[2] ? 8 : sz[1] ? 2 : sz[0] ? 1 : 4;
      w   = mem_word(a);
      r   = '0;
      for (int i = 0; i < nb; i++)
         if (off + i < 8) r[i*8 +: 8] = w[(off+i)*8 +: 8];
`ifdef ATM_BRIDGE_SIGN_EXT_EN
      if (sg && r[nb*8-1])
         for (int i = nb; i < 8; i++) r[i*8 +: 8] = 8'hFF;
`else
      if (sg) r = r;
`endif
      return r;
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         if (rd && !wr && !waitrequest_to_accel)
            sb.push_back(exp_read(cmd[31:0], cmd[DW+32 +: 3], cmd[DW+35]));
         if (read_to_mem && !wq_mem)  pend.push_back({1'b0, address_to_mem});
         if (write_to_mem && !wq_mem) wr_pulses++;
         if (readdatavalid_to_accel) begin
            if (sb.size() == 0) chk("rvalid_unexpected", 64'd1, 64'd0);
            else                chk("rdata", readdata_to_accel, sb.pop_front());
         end
      end
   end

   task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [63:0] d,
                      input logic [2:0] sz, input logic sg);
      bit acc;
      int n;
      cmd = {sg, sz, d, a};
      rd  = r;
      wr  = w;
      acc = 0;
      n   = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = !waitrequest_to_accel;
         @(posedge clk); #1;
         n++;
      end
      rd = 0;
      wr = 0;
      chk("accept", 64'(acc), 64'd1);
   endtask

   task automatic respond(input int n);
      int t;
      for (int k = 0; k < n; k++) begin
         t = 0;
         while (pend.size() == 0 && t < 50) begin
            rvalid_mem = 0;
            @(posedge clk); #1;
            t++;
         end
         if (pend.size() == 0) begin
            chk("resp_pending", 64'd0, 64'd1);
         end else begin
            rdata_mem  = mem_word(pend.pop_front());
            rvalid_mem = 1;
            @(posedge clk); #1;
         end
      end
      rvalid_mem = 0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("sb_drain", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      reset = 0; rd = 0; wr = 0; cmd = '0; wq_mem = 0; rvalid_mem = 0; rdata_mem = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_mem", 64'(read_to_mem), 64'd0);
      chk("rst_wr_mem", 64'(write_to_mem), 64'd0);
      chk("rst_rvalid", 64'(readdatavalid_to_accel), 64'd0);
      chk("rst_rdata", readdata_to_accel, 64'd0);
      chk("rst_addr", 64'(address_to_mem), 64'd0);
      chk("rst_be", 64'(byteenable_to_mem), 64'd0);
      chk("rst_err", 64'(err_status), 64'd0);
      chk("rst_wait", 64'(waitrequest_to_accel), 64'd0);
      reset = 1;
      @(posedge clk); #1;

      // 16-bit write at 0x13
      req(0, 1, 32'h13, 64'hBEEF, 3'b010, 0);
      chk("t1_wr", 64'(write_to_mem), 64'd1);
      chk("t1_addr", 64'(address_to_mem), 64'h13);
      chk("t1_be", 64'(byteenable_to_mem), 64'h18);
      chk("t1_wdata", writedata_to_mem, 64'hBEEF << 24);
      repeat (3) @(posedge clk);
      #1;
      chk("t1_pulses", 64'(wr_pulses), 64'd1);
      chk("t1_wr_low", 64'(write_to_mem), 64'd0);

      // Four reads fill the window, fifth stalls until one response returns
      req(1, 0, 32'h40, 64'd0, 3'b001, 0);
      req(1, 0, 32'h48, 64'd0, 3'b000, 0);
      req(1, 0, 32'h50, 64'd0, 3'b100, 0);
      req(1, 0, 32'h5A, 64'd0, 3'b010, 0);
      cmd = {1'b0, 3'b001, 64'd0, 32'h61};
      rd  = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t2_full", 64'(waitrequest_to_accel), 64'd1);
         @(posedge clk); #1;
      end
      chk("t2_issued", 64'(pend.size()), 64'd4);
      rdata_mem  = mem_word(pend.pop_front());
      rvalid_mem = 1;
      @(negedge clk);
      chk("t2_still_full", 64'(waitrequest_to_accel), 64'd1);
      @(posedge clk); #1;
      rvalid_mem = 0;
      @(negedge clk);
      chk("t2_accept_next", 64'(waitrequest_to_accel), 64'd0);
      @(posedge clk); #1;
      rd = 0;
      respond(4);
      wait_drain();

      // Signed 8-bit read, byte 5 = 0x80
      req(1, 0, 32'h05, 64'd0, 3'b001, 1);
      respond(1);
      wait_drain();
`ifdef ATM_BRIDGE_SIGN_EXT_EN
      chk("t3_rdata", readdata_to_accel, 64'hFFFF_FFFF_FFFF_FF80);
`else
      chk("t3_rdata", readdata_to_accel, 64'h80);
`endif

      // Memory stall for three cycles
      wq_mem = 1;
      req(0, 1, 32'h20, 64'h1122_3344_5566_7788, 3'b100, 0);
      cmd = {1'b0, 3'b100, 64'hA5A5_0000_FFFF_1234, 32'h28};
      wr  = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_wait", 64'(waitrequest_to_accel), 64'd1);
         chk("t4_addr", 64'(address_to_mem), 64'h20);
         chk("t4_wdata", writedata_to_mem, 64'h1122_3344_5566_7788);
         chk("t4_wr", 64'(write_to_mem), 64'd1);
         @(posedge clk); #1;
      end
      wq_mem = 0;
      @(negedge clk);
      chk("t4_release", 64'(waitrequest_to_accel), 64'd0);
      @(posedge clk); #1;
      wr = 0;
      chk("t4_addr2", 64'(address_to_mem), 64'h28);
      repeat (2) @(posedge clk);
      #1;
      chk("t4_pulses", 64'(wr_pulses), 64'd3);
      chk("t5_err_clean", 64'(err_status), 64'd0);

      // Span crossing, spurious response, read/write collision
      req(0, 1, 32'h06, 64'hCAFE_BABE, 3'b000, 0);
      chk("t5_be", 64'(byteenable_to_mem), 64'hC0);
      chk("t5_err_span", 64'(err_status), 64'd1);
      rdata_mem  = {$urandom, $urandom};
      rvalid_mem = 1;
      @(posedge clk); #1;
      rvalid_mem = 0;
      chk("t5_err_spur", 64'(err_status), 64'd3);
      repeat (2) @(posedge clk);
      #1;
      req(1, 1, 32'h30, 64'h55, 3'b001, 0);
      chk("t5_coll_wr", 64'(write_to_mem), 64'd1);
      chk("t5_coll_rd", 64'(read_to_mem), 64'd0);
      chk("t5_coll_be", 64'(byteenable_to_mem), 64'h01);
      chk("t5_err_coll", 64'(err_status), 64'd7);
      repeat (2) @(posedge clk);
      #1;

      // Reset with two reads outstanding
      req(1, 0, 32'h70, 64'd0, 3'b100, 0);
      req(1, 0, 32'h78, 64'd0, 3'b000, 0);
      for (int t = 0; t < 20 && pend.size() < 2; t++) begin
         @(posedge clk); #1;
      end
      chk("t6_issued", 64'(pend.size()), 64'd2);
      reset = 0;
      #1;
      sb.delete();
      chk("t6_rd_mem", 64'(read_to_mem), 64'd0);
      chk("t6_wr_mem", 64'(write_to_mem), 64'd0);
      chk("t6_addr", 64'(address_to_mem), 64'd0);
      chk("t6_be", 64'(byteenable_to_mem), 64'd0);
      chk("t6_wdata", writedata_to_mem, 64'd0);
      chk("t6_rdata", readdata_to_accel, 64'd0);
      chk("t6_err", 64'(err_status), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1;
      @(posedge clk); #1;
      respond(2);
      repeat (3) @(posedge clk);
      #1;
      chk("t6_err_spur", 64'(err_status), 64'd2);
      chk("t6_no_rvalid", 64'(readdatavalid_to_accel), 64'd0);
      chk("final_sb", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
